// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared state and opcode encodings for the calculator operand sequencer
package calc_pkg;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    localparam logic [2:0] OP_XOR       = 3'd0;
    localparam logic [2:0] OP_AND       = 3'd1;
    localparam logic [2:0] OP_OR        = 3'd2;
    localparam logic [2:0] OP_ADD       = 3'd3;
    localparam logic [2:0] OP_SUB       = 3'd4;
    localparam logic [2:0] OP_MAX_VALID = 3'b100;

    function automatic logic is_op_invalid(input logic [2:0] op);
        return op > OP_MAX_VALID;
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - button synchronizer, optional debounce (CALC_DEBOUNCE_EN), rising-edge pulse
module btn_conditioner #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_v1;
    logic r_v2;
    logic r_prev;
    logic r_armed;
    logic r_pulse;
    logic w_level;

`ifdef CALC_DEBOUNCE_EN
    logic        r_level;
    logic [19:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= 1'b0;
            r_cnt   <= 20'd0;
        end else if (r_sync2 != r_level) begin
            if (r_cnt >= DEBOUNCE_CYCLES - 20'd1) begin
                r_level <= r_sync2;
                r_cnt   <= 20'd0;
            end else begin
                r_cnt <= r_cnt + 20'd1;
            end
        end else begin
            r_cnt <= 20'd0;
        end
    end

    assign w_level = r_level;
`else
    logic w_unused_debounce;
    assign w_unused_debounce = ^DEBOUNCE_CYCLES;
    assign w_level           = r_sync2;
`endif

    // r_v1/r_v2 track when the synchronizer holds a real sample; the edge
    // detector only arms once the button has been seen released, so a press
    // held through reset never produces a pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_v1    <= 1'b1;
            r_v2    <= r_v1;
            r_prev  <= w_level;
            r_armed <= r_armed | (r_v2 & ~r_sync2 & ~w_level);
            r_pulse <= w_level & ~r_prev & r_armed;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/calc_operand_sequencer.sv
// rtl/calc_operand_sequencer.sv - ENTER-driven operand/opcode sequencer for the ALU; debounce via CALC_DEBOUNCE_EN
module calc_operand_sequencer
    import calc_pkg::*;
#(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sw,
    input  logic [2:0] op_sw,
    input  logic       btn_enter,
    input  logic       btn_clear,
    input  logic [7:0] alu_result,
    output logic [2:0] alu_opcode,
    output logic [7:0] alu_in1,
    output logic [7:0] alu_in2,
    output logic [7:0] disp_value,
    output logic [2:0] phase,
    output logic       result_valid,
    output logic       op_invalid
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_in1;
    logic [7:0] r_in2;
    logic [2:0] r_opcode;
    logic [7:0] r_result;
    logic [7:0] w_in1_nxt;
    logic [7:0] w_in2_nxt;
    logic [2:0] w_opcode_nxt;
    logic [7:0] w_result_nxt;
    logic       w_enter_p;
    logic       w_clear_p;

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_btn  (btn_enter),
        .o_pulse(w_enter_p)
    );

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_btn  (btn_clear),
        .o_pulse(w_clear_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_A;
            r_in1    <= 8'h00;
            r_in2    <= 8'h00;
            r_opcode <= 3'b000;
            r_result <= 8'h00;
        end else begin
            r_state  <= w_state_nxt;
            r_in1    <= w_in1_nxt;
            r_in2    <= w_in2_nxt;
            r_opcode <= w_opcode_nxt;
            r_result <= w_result_nxt;
        end
    end

    // Clear wins over a same-cycle enter; S_EXEC advances unconditionally.
    always_comb begin
        w_state_nxt  = r_state;
        w_in1_nxt    = r_in1;
        w_in2_nxt    = r_in2;
        w_opcode_nxt = r_opcode;
        w_result_nxt = r_result;
        if (w_clear_p) begin
            w_state_nxt  = S_A;
            w_in1_nxt    = 8'h00;
            w_in2_nxt    = 8'h00;
            w_opcode_nxt = 3'b000;
            w_result_nxt = 8'h00;
        end else begin
            case (r_state)
                S_A: if (w_enter_p) begin
                    w_in1_nxt   = sw;
                    w_state_nxt = S_B;
                end
                S_B: if (w_enter_p) begin
                    w_in2_nxt   = sw;
                    w_state_nxt = S_OP;
                end
                S_OP: if (w_enter_p) begin
                    w_opcode_nxt = op_sw;
                    w_state_nxt  = S_EXEC;
                end
                S_EXEC: begin
                    w_result_nxt = alu_result;
                    w_state_nxt  = S_SHOW;
                end
                S_SHOW: if (w_enter_p) begin
                    w_in1_nxt   = r_result;
                    w_state_nxt = S_B;
                end
                default: w_state_nxt = S_A;
            endcase
        end
    end

    always_comb begin
        disp_value = r_result;
        case (r_state)
            S_A, S_B: disp_value = sw;
            S_OP:     disp_value = {5'b0, op_sw};
            default:  disp_value = r_result;
        endcase
    end

    assign alu_opcode   = r_opcode;
    assign alu_in1      = r_in1;
    assign alu_in2      = r_in2;
    assign phase        = r_state;
    assign result_valid = (r_state == S_SHOW);
    assign op_invalid   = is_op_invalid(r_opcode);

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// tb/tb_calc_operand_sequencer.sv - self-checking bench for calc_operand_sequencer
module tb_calc_operand_sequencer;

`ifdef CALC_DEBOUNCE_EN
    localparam int D_EFF = 4;
`else
    localparam int D_EFF = 0;
`endif
    localparam int HOLD = D_EFF + 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sw = 8'h00;
    logic [2:0] op_sw = 3'b000;
    logic       btn_enter = 1'b0;
    logic       btn_clear = 1'b0;
    logic [7:0] alu_result;
    logic [2:0] alu_opcode;
    logic [7:0] alu_in1;
    logic [7:0] alu_in2;
    logic [7:0] disp_value;
    logic [2:0] phase;
    logic       result_valid;
    logic       op_invalid;

    int n_checks = 0;
    int n_errors = 0;

    calc_operand_sequencer #(.DEBOUNCE_CYCLES(20'd4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw          (sw),
        .op_sw       (op_sw),
        .btn_enter   (btn_enter),
        .btn_clear   (btn_clear),
        .alu_result  (alu_result),
        .alu_opcode  (alu_opcode),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .disp_value  (disp_value),
        .phase       (phase),
        .result_valid(result_valid),
        .op_invalid  (op_invalid)
    );

    always #5 clk = ~clk;

    // Stand-in for the external combinational ALU
    always_comb begin
        case (alu_opcode)
            3'd0:    alu_result = alu_in1 ^ alu_in2;
            3'd1:    alu_result = alu_in1 & alu_in2;
            3'd2:    alu_result = alu_in1 | alu_in2;
            3'd3:    alu_result = alu_in1 + alu_in2;
            3'd4:    alu_result = alu_in1 - alu_in2;
            default: alu_result = 8'h00;
        endcase
    end

    function automatic int ref_result(input int a, input int b, input int op);
        case (op)
            0:       return a ^ b;
            1:       return a & b;
            2:       return a | b;
            3:       return (a + b) % 256;
            4:       return (a - b + 256) % 256;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic press(input logic do_enter, input logic do_clear);
        @(posedge clk);
        #1;
        btn_enter = do_enter;
        btn_clear = do_clear;
        repeat (HOLD) @(posedge clk);
        #1;
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        repeat (HOLD) @(posedge clk);
        #1;
    endtask

    task automatic enter_val(input logic [7:0] v);
        sw = v;
        press(1'b1, 1'b0);
    endtask

    task automatic enter_op(input logic [2:0] op);
        op_sw = op;
        press(1'b1, 1'b0);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [7:0] exp_res;
        logic       exp_inv;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int a, b, op, exp_r, last_res;
        bit have_res;

        vecs[0] = '{8'h0F, 8'h33, 3'd3, 8'h42, 1'b0};
        vecs[1] = '{8'hFF, 8'h02, 3'd3, 8'h01, 1'b0};
        vecs[2] = '{8'hAA, 8'h0F, 3'd0, 8'hA5, 1'b0};
        vecs[3] = '{8'hF0, 8'h3C, 3'd1, 8'h30, 1'b0};
        vecs[4] = '{8'hF0, 8'h0F, 3'd2, 8'hFF, 1'b0};
        vecs[5] = '{8'h10, 8'h20, 3'd4, 8'hF0, 1'b0};
        vecs[6] = '{8'h12, 8'h34, 3'd7, 8'h00, 1'b1};

        // Reset with ENTER held down
        btn_enter = 1'b1;
        sw = 8'h5A;
        repeat (3) @(posedge clk);
        #1;
        check("rst_phase", phase, 3'd0);
        check("rst_disp", disp_value, 8'h5A);
        check("rst_valid", result_valid, 1'b0);
        check("rst_in1", alu_in1, 8'h00);
        check("rst_opcode", alu_opcode, 3'd0);
        check("rst_invalid", op_invalid, 1'b0);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("held_no_pulse", phase, 3'd0);
        btn_enter = 1'b0;
        repeat (HOLD) @(posedge clk);
        #1;
        check("release_no_pulse", phase, 3'd0);

        for (int i = 0; i < 7; i++) begin
            press(1'b0, 1'b1);
            enter_val(vecs[i].a);
            check($sformatf("v%0d_phase_b", i), phase, 3'd1);
            check($sformatf("v%0d_in1", i), alu_in1, vecs[i].a);
            enter_val(vecs[i].b);
            check($sformatf("v%0d_phase_op", i), phase, 3'd2);
            check($sformatf("v%0d_in2", i), alu_in2, vecs[i].b);
            enter_op(vecs[i].op);
            check($sformatf("v%0d_phase_show", i), phase, 3'd4);
            check($sformatf("v%0d_valid", i), result_valid, 1'b1);
            check($sformatf("v%0d_disp", i), disp_value, vecs[i].exp_res);
            check($sformatf("v%0d_invalid", i), op_invalid, vecs[i].exp_inv);
        end

        // Chain: 0F+33=42, then 42-50 wraps to F2
        press(1'b0, 1'b1);
        enter_val(8'h0F);
        enter_val(8'h33);
        enter_op(3'd3);
        check("chain_first", disp_value, 8'h42);
        enter_val(8'h00);
        check("chain_phase_b", phase, 3'd1);
        check("chain_in1", alu_in1, 8'h42);
        enter_val(8'h50);
        enter_op(3'd4);
        check("chain_result", disp_value, 8'hF2);

        // S_OP -> S_EXEC -> S_SHOW edge-by-edge timing
        press(1'b0, 1'b1);
        enter_val(8'h05);
        enter_val(8'h03);
        op_sw = 3'd3;
        @(posedge clk);
        #1;
        btn_enter = 1'b1;
        for (int e = 1; e <= D_EFF + 5; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e == D_EFF + 3) check("lat_still_op", phase, 3'd2);
            if (e == D_EFF + 4) begin
                check("lat_exec", phase, 3'd3);
                check("lat_exec_valid", result_valid, 1'b0);
                check("lat_exec_opcode", alu_opcode, 3'd3);
            end
            if (e == D_EFF + 5) begin
                check("lat_show", phase, 3'd4);
                check("lat_show_valid", result_valid, 1'b1);
                check("lat_show_disp", disp_value, 8'h08);
            end
        end
        #1;
        btn_enter = 1'b0;
        repeat (HOLD) @(posedge clk);
        #1;

        // Clear and enter together in S_B
        press(1'b0, 1'b1);
        enter_val(8'h11);
        check("simul_pre_in1", alu_in1, 8'h11);
        press(1'b1, 1'b1);
        check("simul_phase", phase, 3'd0);
        check("simul_in1", alu_in1, 8'h00);
        check("simul_in2", alu_in2, 8'h00);
        check("simul_opcode", alu_opcode, 3'd0);

`ifdef CALC_DEBOUNCE_EN
        // 3-cycle glitch shorter than the debounce window
        @(posedge clk);
        #1;
        btn_enter = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        btn_enter = 1'b0;
        repeat (HOLD + 4) @(posedge clk);
        #1;
        check("glitch_no_pulse", phase, 3'd0);
`endif

        // Asynchronous reset mid-sequence
        enter_val(8'h77);
        enter_val(8'h22);
        check("midrst_pre", alu_in1, 8'h77);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_phase", phase, 3'd0);
        check("midrst_in1", alu_in1, 8'h00);
        check("midrst_in2", alu_in2, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        // Randomized operations, with random chaining, against the model
        have_res = 1'b0;
        last_res = 0;
        for (int i = 0; i < 25; i++) begin
            if (have_res && ($urandom_range(0, 1) == 1)) begin
                a = last_res;
                enter_val(8'($urandom_range(0, 255)));
                check($sformatf("rnd%0d_chain_in1", i), alu_in1, a[7:0]);
            end else begin
                press(1'b0, 1'b1);
                a = $urandom_range(0, 255);
                enter_val(a[7:0]);
            end
            b = $urandom_range(0, 255);
            op = $urandom_range(0, 7);
            enter_val(b[7:0]);
            enter_op(op[2:0]);
            exp_r = ref_result(a, b, op);
            check($sformatf("rnd%0d_disp", i), disp_value, exp_r[7:0]);
            check($sformatf("rnd%0d_valid", i), result_valid, 1'b1);
            check($sformatf("rnd%0d_invalid", i), op_invalid, (op > 4) ? 1'b1 : 1'b0);
            last_res = exp_r;
            have_res = 1'b1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/calc_operand_sequencer.md
# calc_operand_sequencer

Sequential front end that drives the calculator's combinational ALU. Collects operand A, operand B and a 3-bit opcode from board switches on successive ENTER presses, presents them to the ALU, registers the 8-bit result and holds it for display. Supports chained operation: the held result becomes the next operand A.

## Interface

Parameters:
- DEBOUNCE_CYCLES, 20'd1_000_000, stable-level cycles required before a button change is accepted (used only with CALC_DEBOUNCE_EN)

Ports:
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- sw  in  8  operand switches
- op_sw  in  3  opcode switches
- btn_enter  in  1  raw ENTER button, active-high
- btn_clear  in  1  raw CLEAR button, active-high
- alu_result  in  8  combinational result returned by the ALU
- alu_opcode  out  3  registered opcode to ALU
- alu_in1  out  8  registered operand A to ALU
- alu_in2  out  8  registered operand B to ALU
- disp_value  out  8  value for the display driver
- phase  out  3  one-hot-free state code for LEDs (S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_SHOW=4)
- result_valid  out  1  high while a captured result is held (S_SHOW)
- op_invalid  out  1  high when the latched opcode is above 3'b100 (ALU returns 0)

## Operation

- Button path: each button goes through a 2-flop synchronizer, then a rising-edge detector producing a 1-cycle pulse (enter_p, clear_p).
- States and transitions (on enter_p unless noted):
  - S_A: disp_value = sw; enter_p -> alu_in1 <= sw, go S_B.
  - S_B: disp_value = sw; enter_p -> alu_in2 <= sw, go S_OP.
  - S_OP: disp_value = {5'b0, op_sw}; enter_p -> alu_opcode <= op_sw, go S_EXEC.
  - S_EXEC: single cycle, no button needed; result_q <= alu_result; go S_SHOW.
  - S_SHOW: disp_value = result_q; result_valid = 1; enter_p -> alu_in1 <= result_q, go S_B (chain).
- clear_p in any state: alu_in1, alu_in2, alu_opcode, result_q <= 0; go S_A. Clear has priority over a same-cycle enter_p.
- op_invalid = (alu_opcode > 3'b100), combinational from the registered opcode; informational only, sequencing unchanged.
- Arithmetic is entirely in the ALU; result is taken as 8 bits, carry/borrow discarded, wrap-around modulo 256.
- enter_p arriving in S_EXEC is ignored (cannot occur from a real press, but must not advance state).

## Timing

- Reset (async assert, sync release on clk): state = S_A; alu_opcode = 3'b000, alu_in1 = alu_in2 = 8'h00, result_q = 8'h00; disp_value = sw (S_A); result_valid = 0; op_invalid = 0; synchronizer/edge flops 0 so a button held through reset does not generate a pulse until released and pressed again.
- Without debounce: enter_p asserts 3 cycles after btn_enter rises (2 sync + edge); register update and state change on the following edge.
- Operand/opcode registers update on the same edge the state leaves S_A/S_B/S_OP.
- S_OP -> S_SHOW latency: 2 cycles after enter_p (EXEC, then SHOW); result_valid rises on the second.
- alu_in1/in2/opcode remain stable throughout S_EXEC so the ALU output is settled one full cycle before capture.
- Reset asserted mid-sequence discards all captured values immediately.

## Configuration

- CALC_DEBOUNCE_EN defined: a debounce counter per button follows the synchronizer; the filtered level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; edge detection operates on the filtered level. Press-to-pulse latency = DEBOUNCE_CYCLES + 3.
- Not defined: no counter; edge detect directly on synchronizer output; DEBOUNCE_CYCLES unused.

## Structure

- Shared package calc_pkg: state encoding constants (S_A..S_SHOW), opcode constants OP_XOR=0, OP_AND=1, OP_OR=2, OP_ADD=3, OP_SUB=4, OP_MAX_VALID=3'b100.
- One sub-module btn_conditioner (sync, optional debounce, edge pulse), instantiated twice.

## Test plan

- Reset with btn_enter held high -> state S_A, all outputs 0, no enter_p until release and re-press.
- Enter sw=8'h0F, 8'h33, op=3'b011 -> alu_in1=0F, alu_in2=33, result_q=8'h42, result_valid high, disp_value=42.
- Chain: from result 8'h42, enter sw=8'h50, op=3'b100 -> alu_in1=42, result 8'hF2 (wrap).
- Overflow: A=8'hFF, B=8'h02, op=3'b011 -> disp_value=8'h01.
- op=3'b111 -> op_invalid=1, result 8'h00, still reaches S_SHOW.
- Simultaneous clear and enter pulses in S_B -> S_A, all operands 0; with CALC_DEBOUNCE_EN and DEBOUNCE_CYCLES=4, a 3-cycle glitch produces no pulse.
